// File: rtl/phase_gen_pkg.sv
// rtl/phase_gen_pkg.sv - shared constants, state encoding, sine table and saturation for phase_shift_gen
package phase_gen_pkg;

  localparam int N_SAMPLES = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // round(32767*sin(2*pi*k/32)), full Q15 scale; narrowed per sample width by sin_s()
  localparam int SIN_Q15 [0:31] = '{
         0,   6393,  12539,  18204,  23170,  27245,  30273,  32137,
     32767,  32137,  30273,  27245,  23170,  18204,  12539,   6393,
         0,  -6393, -12539, -18204, -23170, -27245, -30273, -32137,
    -32767, -32137, -30273, -27245, -23170, -18204, -12539,  -6393
  };

  // Table entry scaled to an m-bit sample (arithmetic shift keeps the floor rounding)
  function automatic int sin_s(logic [4:0] k, int m);
    return SIN_Q15[k] >>> (17 - m);
  endfunction

  // Clamp to the signed m-bit range
  function automatic int sat(int v, int m);
    int hi;
    int lo;
    hi = (1 << (m - 1)) - 1;
    lo = -(1 << (m - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/deg_to_lag.sv
// rtl/deg_to_lag.sv - combinational conversion of a lag angle in degrees to a lag in samples
module deg_to_lag
  import phase_gen_pkg::*;
(
  input  logic [15:0] phase_deg,
  output logic [4:0]  lag,
  output logic        illegal
);

  logic [21:0] scaled;

  // Rounded degrees-to-samples: (deg*32 + 180) / 360, folded so 360 maps back to 0
  assign scaled  = {1'b0, phase_deg, 5'b0} + 22'd180;
  assign lag     = 5'((scaled / 22'd360) % 22'(N_SAMPLES));
  assign illegal = (phase_deg > 16'd359);

endmodule

// File: rtl/phase_shift_gen.sv
// rtl/phase_shift_gen.sv - reference sine plus lagged copy; optional third phase Vc under PHASE_GEN_3PH_EN
module phase_shift_gen
  import phase_gen_pkg::*;
#(
  parameter int M = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [15:0]         phase_deg,
  input  logic signed [M-1:0] offset_ref,
  input  logic signed [M-1:0] offset_in,
  output logic signed [M-1:0] Vref,
  output logic signed [M-1:0] Vin,
`ifdef PHASE_GEN_3PH_EN
  output logic signed [M-1:0] Vc,
`endif
  output logic                valid,
  output logic [4:0]          lag,
  output logic                phase_err
);

  state_t            state;
  logic [4:0]        idx;
  logic [4:0]        new_lag;
  logic              deg_illegal;
  logic              load_pt;
  logic [4:0]        idx_in;
  logic signed [M:0] sum_ref;
  logic signed [M:0] sum_in;

  deg_to_lag u_deg_to_lag (
    .phase_deg (phase_deg),
    .lag       (new_lag),
    .illegal   (deg_illegal)
  );

  // Lag may only change when a period starts: entering RUN, or the idx 31->0 wrap
  assign load_pt = (state == IDLE) ? en : (en && (idx == 5'(N_SAMPLES - 1)));

  // Sample sums in M+1 bits; 5-bit index subtraction gives the mod-32 wrap for free
  assign idx_in  = idx - lag;
  assign sum_ref = {offset_ref[M-1], offset_ref} + (M+1)'(sin_s(idx, M));
  assign sum_in  = {offset_in[M-1], offset_in} + (M+1)'(sin_s(idx_in, M));

`ifdef PHASE_GEN_3PH_EN
  logic [4:0]        idx_c;
  logic signed [M:0] sum_c;
  assign idx_c = idx - {lag[3:0], 1'b0};
  assign sum_c = {offset_in[M-1], offset_in} + (M+1)'(sin_s(idx_c, M));
`endif

  // FSM, sample index, lag register and registered sample outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= 5'd0;
      lag       <= 5'd0;
      Vref      <= '0;
      Vin       <= '0;
      valid     <= 1'b0;
      phase_err <= 1'b0;
`ifdef PHASE_GEN_3PH_EN
      Vc        <= '0;
`endif
    end else begin
      phase_err <= load_pt && deg_illegal;
      if (load_pt && !deg_illegal) begin
        lag <= new_lag;
      end
      if (state == RUN && en) begin
        Vref  <= M'(sat(int'(sum_ref), M));
        Vin   <= M'(sat(int'(sum_in), M));
        valid <= 1'b1;
        idx   <= idx + 5'd1;
`ifdef PHASE_GEN_3PH_EN
        Vc    <= M'(sat(int'(sum_c), M));
`endif
      end else begin
        Vref  <= offset_ref;
        Vin   <= offset_in;
        valid <= 1'b0;
        idx   <= 5'd0;
`ifdef PHASE_GEN_3PH_EN
        Vc    <= offset_in;
`endif
      end
      case (state)
        IDLE:    if (en)  state <= RUN;
        RUN:     if (!en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_shift_gen.sv
// tb/tb_phase_shift_gen.sv - randomized and directed checks of phase_shift_gen against a sample-count model
module tb_phase_shift_gen;

  localparam int    M  = 14;
  localparam real   PI = 3.14159265358979;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                en = 1'b0;
  logic [15:0]         phase_deg = 16'd0;
  logic signed [M-1:0] offset_ref = '0;
  logic signed [M-1:0] offset_in = '0;
  logic signed [M-1:0] Vref;
  logic signed [M-1:0] Vin;
`ifdef PHASE_GEN_3PH_EN
  logic signed [M-1:0] Vc;
`endif
  logic                valid;
  logic [4:0]          lag;
  logic                phase_err;

  int n_checks = 0;
  int n_pass   = 0;

  // model: whether samples are flowing, position in period, lag in force
  bit m_run = 0;
  int m_pos = 0;
  int m_lag = 0;
  int e_vref, e_vin, e_vc, e_valid, e_err, e_k;

  phase_shift_gen #(.M(M)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .phase_deg  (phase_deg),
    .offset_ref (offset_ref),
    .offset_in  (offset_in),
    .Vref       (Vref),
    .Vin        (Vin),
`ifdef PHASE_GEN_3PH_EN
    .Vc         (Vc),
`endif
    .valid      (valid),
    .lag        (lag),
    .phase_err  (phase_err)
  );

  always #5 clk = ~clk;

  function automatic int wrap32(int x);
    return ((x % 32) + 32) % 32;
  endfunction

  // Sine sample k of an M-bit stream, computed from the math definition
  function automatic int s_ref(int k);
    real x;
    int  q;
    x = 32767.0 * $sin(2.0 * PI * real'(k) / 32.0);
    q = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    return $rtoi($floor(real'(q) / real'(1 << (17 - M))));
  endfunction

  function automatic int clampm(int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  function automatic int lag_of(int d);
    return ((d * 32 + 180) / 360) % 32;
  endfunction

  task automatic check(string tag, int obs, int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_load();
    if (phase_deg > 16'd359) e_err = 1;
    else m_lag = lag_of(int'(phase_deg));
  endtask

  // Predict what the outputs hold after the edge just taken
  task automatic model_edge();
    e_err = 0;
    e_k   = -1;
    if (m_run && en) begin
      e_k     = m_pos;
      e_vref  = clampm(int'(offset_ref) + s_ref(e_k));
      e_vin   = clampm(int'(offset_in) + s_ref(wrap32(e_k - m_lag)));
      e_vc    = clampm(int'(offset_in) + s_ref(wrap32(e_k - 2 * m_lag)));
      e_valid = 1;
      m_pos   = (m_pos + 1) % 32;
      if (m_pos == 0) model_load();
    end else begin
      e_vref  = int'(offset_ref);
      e_vin   = int'(offset_in);
      e_vc    = int'(offset_in);
      e_valid = 0;
      if (en) model_load();
      m_pos   = 0;
    end
    m_run = en;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
    check("vref", int'(Vref), e_vref);
    check("vin", int'(Vin), e_vin);
    check("valid", int'(valid), e_valid);
    check("lag", int'(lag), m_lag);
    check("phase_err", int'(phase_err), e_err);
`ifdef PHASE_GEN_3PH_EN
    check("vc", int'(Vc), e_vc);
`endif
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_vref"}, int'(Vref), 0);
    check({tag, "_vin"}, int'(Vin), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_lag"}, int'(lag), 0);
    check({tag, "_perr"}, int'(phase_err), 0);
`ifdef PHASE_GEN_3PH_EN
    check({tag, "_vc"}, int'(Vc), 0);
`endif
  endtask

  task automatic load_angle(int d);
    en = 1'b0;
    cycle();
    phase_deg = 16'(d);
    en = 1'b1;
    cycle();
  endtask

  int spot_deg [5] = '{354, 355, 11, 6, 5};
  int spot_lag [5] = '{31, 0, 1, 1, 0};

  initial begin
    // reset
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // 90 degrees, zero offsets
    phase_deg = 16'd90;
    en = 1'b1;
    for (int i = 0; i < 70; i++) begin
      cycle();
      if (e_k == 8)  check("vref_peak", int'(Vref), 4095);
      if (e_k == 16) check("vref_zero", int'(Vref), 0);
      if (e_k == 17) check("vref_falling", (Vref < 0) ? 1 : 0, 1);
      if (e_k == 24) check("vref_trough", int'(Vref), -4096);
    end
    check("lag_90", int'(lag), 8);

    // every legal angle, then boundary values against fixed answers
    for (int d = 0; d < 360; d++) load_angle(d);
    for (int i = 0; i < 5; i++) begin
      load_angle(spot_deg[i]);
      check("lag_spot", int'(lag), spot_lag[i]);
    end

    // angle change mid-period only takes effect at the wrap
    load_angle(45);
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (e_k == 10) phase_deg = 16'd180;
      if (e_k > 10 && e_k < 31 && i < 32) check("lag_hold", int'(lag), 4);
      if (e_k == 31 && i < 32) check("lag_new", int'(lag), 16);
    end

    // illegal angle at load points
    phase_deg = 16'd400;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (e_k == 31) check("perr_wrap", int'(phase_err), 1);
    end
    check("lag_kept", int'(lag), 16);
    offset_ref = 14'sd300;
    en = 1'b0;
    cycle();
    check("stop_valid", int'(valid), 0);
    check("stop_vref", int'(Vref), 300);
    en = 1'b1;
    cycle();
    check("perr_start", int'(phase_err), 1);

    // saturation, then asynchronous reset in mid-period
    offset_ref = 14'sd8000;
    offset_in  = -14'sd8000;
    load_angle(0);
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (e_k == 8)  check("vref_clamp", int'(Vref), 8191);
      if (e_k == 24) check("vin_clamp", int'(Vin), -8192);
      if (e_k == 20 && i > 32) break;
    end
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    m_run = 0;
    m_pos = 0;
    m_lag = 0;
    #1;
    rst = 1'b1;

    // randomized angles, offsets and run gaps
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(9) == 0) phase_deg = 16'($urandom_range(399));
      if ($urandom_range(19) == 0) offset_ref = 14'($urandom_range(16383));
      if ($urandom_range(19) == 0) offset_in = 14'($urandom_range(16383));
      en = ($urandom_range(29) != 0);
      cycle();
    end

`ifdef PHASE_GEN_3PH_EN
    // balanced three-phase set
    offset_ref = '0;
    offset_in  = '0;
    load_angle(120);
    for (int i = 0; i < 40; i++) cycle();
    check("lag_120", int'(lag), 11);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
